// File: rtl/seg_scan_if.sv
// seg_scan_if: control/data and display bus of the multiplexed seven-segment scanner
interface seg_scan_if #(parameter int DIGITS = 8);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_mask;
    logic                  lzb;
    logic [7:0]            seg;
    logic [DIGITS-1:0]     an;
    logic                  frame;
    modport master (output en, load, value, dp_mask, lzb, input seg, an, frame);
    modport slave  (input en, load, value, dp_mask, lzb, output seg, an, frame);
endinterface

// File: rtl/seg_scan.sv
// seg_scan: multiplexed N-digit hex seven-segment scanner with active-low segments and anodes
module seg_scan #(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 1000
) (
    input logic       clk,
    input logic       rst,
    seg_scan_if.slave bus
);
    localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;

    logic [4*DIGITS-1:0] sval;
    logic [DIGITS-1:0]   sdp;
    logic [CW-1:0]       cnt;
    logic [IW-1:0]       idx;
    logic                tc;
    logic                wrap;
    logic                nz;
    logic                blank;
    logic [3:0]          nib;

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'h0: dec = 7'b0000001;
            4'h1: dec = 7'b1001111;
            4'h2: dec = 7'b0010010;
            4'h3: dec = 7'b0000110;
            4'h4: dec = 7'b1001100;
            4'h5: dec = 7'b0100100;
            4'h6: dec = 7'b0100000;
            4'h7: dec = 7'b0001111;
            4'h8: dec = 7'b0000000;
            4'h9: dec = 7'b0000100;
            4'hA: dec = 7'b0001000;
            4'hB: dec = 7'b1100000;
            4'hC: dec = 7'b0110001;
            4'hD: dec = 7'b1000010;
            4'hE: dec = 7'b0110000;
            default: dec = 7'b0111000;
        endcase
    endfunction

    // terminal count, wrap detection, current nibble and leading-zero test for the active digit
    always_comb begin
        tc   = cnt == CW'(SCAN_DIV - 1);
        wrap = tc && idx == IW'(DIGITS - 1);
        nib  = sval[{idx, 2'b00} +: 4];
        nz   = 1'b0;
        for (int j = 0; j < DIGITS; j++)
            nz = nz | ((j >= int'(idx)) && (sval[4*j +: 4] != 4'd0));
        blank = bus.lzb && idx != '0 && !nz;
    end

    // shadow registers capture on load regardless of en
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sval <= '0;
            sdp  <= '0;
        end else if (bus.load) begin
            sval <= bus.value;
            sdp  <= bus.dp_mask;
        end
    end

    // refresh divider and digit index; disabled scan parks at digit 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (!bus.en) begin
            cnt <= '0;
            idx <= '0;
        end else if (tc) begin
            cnt <= '0;
            idx <= wrap ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // registered display outputs and frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.seg   <= 8'hFF;
            bus.an    <= '1;
            bus.frame <= 1'b0;
        end else begin
            bus.frame <= bus.en && wrap;
            bus.an    <= bus.en ? ~(DIGITS'(1) << idx) : '1;
            bus.seg   <= bus.en ? {blank ? 7'h7F : dec(nib), ~sdp[idx]} : 8'hFF;
        end
    end
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: directed self-checking bench for seg_scan with DIGITS=4, SCAN_DIV=3
module tb_seg_scan;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    seg_scan_if #(.DIGITS(4)) bus();
    seg_scan #(.DIGITS(4), .SCAN_DIV(3)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // park the scan, load new shadow data, then enable; returns just after the first enabled edge
    task automatic restart(input logic [15:0] v, input logic [3:0] d);
        bus.en = 1'b0;
        bus.load = 1'b0;
        step();
        bus.value = v;
        bus.dp_mask = d;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        bus.en = 1'b1;
        step();
    endtask

    task automatic test_reset;
        bus.en = 1'b0;
        bus.load = 1'b0;
        bus.lzb = 1'b0;
        bus.value = '0;
        bus.dp_mask = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            checks++;
            if (bus.seg !== 8'hFF || bus.an !== 4'b1111 || bus.frame !== 1'b0) begin
                errors++;
                $display("FAIL reset_blank cyc%0d: seg=%b an=%b frame=%b, want seg=11111111 an=1111 frame=0", k, bus.seg, bus.an, bus.frame);
            end
            step();
        end
    endtask

    task automatic test_scan;
        logic [7:0] exp_seg [4];
        logic [3:0] exp_an;
        logic       exp_fr;
        exp_seg = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101};
        bus.lzb = 1'b0;
        restart(16'h3210, 4'b0000);
        for (int k = 0; k < 24; k++) begin
            exp_an = ~(4'b0001 << ((k / 3) % 4));
            exp_fr = (k % 12) == 11;
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg[(k / 3) % 4] || bus.frame !== exp_fr) begin
                errors++;
                $display("FAIL scan k%0d: an=%b seg=%b frame=%b, want an=%b seg=%b frame=%b", k, bus.an, bus.seg, bus.frame, exp_an, exp_seg[(k / 3) % 4], exp_fr);
            end
            step();
        end
    endtask

    task automatic test_hex_dp;
        logic [7:0] exp_seg [4];
        logic [3:0] exp_an;
        exp_seg = '{8'b01100010, 8'b10000101, 8'b01100000, 8'b01110001};
        bus.lzb = 1'b0;
        restart(16'hFEDC, 4'b0101);
        for (int k = 0; k < 12; k++) begin
            exp_an = ~(4'b0001 << (k / 3));
            checks++;
            if (bus.an !== exp_an || bus.seg !== exp_seg[k / 3]) begin
                errors++;
                $display("FAIL hex_dp k%0d: an=%b seg=%b, want an=%b seg=%b", k, bus.an, bus.seg, exp_an, exp_seg[k / 3]);
            end
            step();
        end
    endtask

    task automatic test_lzb;
        logic [15:0] vals [3];
        logic [3:0]  dps  [3];
        logic        lz   [3];
        logic [7:0]  exp_seg [3][4];
        vals = '{16'h0005, 16'h0005, 16'h0000};
        dps  = '{4'b0100, 4'b0100, 4'b0000};
        lz   = '{1'b1, 1'b0, 1'b1};
        exp_seg = '{'{8'b01001001, 8'hFF, 8'hFE, 8'hFF},
                    '{8'b01001001, 8'b00000011, 8'b00000010, 8'b00000011},
                    '{8'b00000011, 8'hFF, 8'hFF, 8'hFF}};
        for (int c = 0; c < 3; c++) begin
            bus.lzb = lz[c];
            restart(vals[c], dps[c]);
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (bus.an !== ~(4'b0001 << (k / 3)) || bus.seg !== exp_seg[c][k / 3]) begin
                    errors++;
                    $display("FAIL lzb case%0d k%0d: an=%b seg=%b, want an=%b seg=%b", c, k, bus.an, bus.seg, ~(4'b0001 << (k / 3)), exp_seg[c][k / 3]);
                end
                step();
            end
        end
        bus.lzb = 1'b0;
    endtask

    task automatic test_load_timing;
        restart(16'h1111, 4'b0000);
        bus.value = 16'h7777;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        checks++;
        if (bus.seg !== 8'b10011111 || bus.an !== 4'b1110) begin
            errors++;
            $display("FAIL load_edge: seg=%b an=%b, want seg=10011111 an=1110", bus.seg, bus.an);
        end
        bus.value = 16'h8888;
        step();
        checks++;
        if (bus.seg !== 8'b00011111 || bus.an !== 4'b1110) begin
            errors++;
            $display("FAIL load_next: seg=%b an=%b, want seg=00011111 an=1110", bus.seg, bus.an);
        end
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (bus.seg !== 8'b00011111) begin
                errors++;
                $display("FAIL unloaded_value k%0d: seg=%b, want 00011111", k, bus.seg);
            end
        end
    endtask

    task automatic test_back_to_back;
        restart(16'h1111, 4'b0000);
        step();
        bus.value = 16'h2222;
        bus.load = 1'b1;
        step();
        bus.load = 1'b0;
        step();
        checks++;
        if (bus.an !== 4'b1101 || bus.seg !== 8'b00100101) begin
            errors++;
            $display("FAIL load_and_advance: an=%b seg=%b, want an=1101 seg=00100101", bus.an, bus.seg);
        end
    endtask

    task automatic test_mid_events;
        restart(16'h3210, 4'b0000);
        for (int k = 0; k < 6; k++) step();
        checks++;
        if (bus.an !== 4'b1011 || bus.seg !== 8'b00100101) begin
            errors++;
            $display("FAIL at_digit2: an=%b seg=%b, want an=1011 seg=00100101", bus.an, bus.seg);
        end
        bus.en = 1'b0;
        step();
        checks++;
        if (bus.an !== 4'b1111 || bus.seg !== 8'hFF) begin
            errors++;
            $display("FAIL en_drop: an=%b seg=%b, want an=1111 seg=11111111", bus.an, bus.seg);
        end
        bus.en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if (bus.an !== 4'b1110 || bus.seg !== 8'b00000011) begin
                errors++;
                $display("FAIL en_rise k%0d: an=%b seg=%b, want an=1110 seg=00000011", k, bus.an, bus.seg);
            end
        end
        step();
        checks++;
        if (bus.an !== 4'b1101) begin
            errors++;
            $display("FAIL en_rise_adv: an=%b, want 1101", bus.an);
        end
    endtask

    task automatic test_async_rst;
        restart(16'h3210, 4'b0000);
        for (int k = 0; k < 11; k++) step();
        checks++;
        if (bus.frame !== 1'b1 || bus.an !== 4'b0111) begin
            errors++;
            $display("FAIL pre_rst_frame: frame=%b an=%b, want frame=1 an=0111", bus.frame, bus.an);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.seg !== 8'hFF || bus.an !== 4'b1111 || bus.frame !== 1'b0) begin
            errors++;
            $display("FAIL async_rst: seg=%b an=%b frame=%b, want seg=11111111 an=1111 frame=0", bus.seg, bus.an, bus.frame);
        end
        #1;
        rst = 1'b0;
        step();
        checks++;
        if (bus.an !== 4'b1110 || bus.seg !== 8'b00000011) begin
            errors++;
            $display("FAIL post_rst_shadow: an=%b seg=%b, want an=1110 seg=00000011", bus.an, bus.seg);
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_hex_dp();
        test_lzb();
        test_load_timing();
        test_back_to_back();
        test_mid_events();
        test_async_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
